wb_rr_arbiter: RTL and testbench

//  - Two-master Wishbone bus arbiter for the dual-hart system; sits between core0/core1 and the slave-side decode.
//  - Grants the shared bus round-robin and holds the grant for a master's whole CYC.
//  - Routes the granted master's request to the slave side and the slave response back to that master only.
//  - Watchdog: a transfer left unacknowledged past TIMEOUT cycles is answered with ERR and the bus is freed.

---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_watchdog.sv | 31 +++
 rtl/wb_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_rr_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the dual-hart Wishbone arbiter: FSM encoding and default bus widths.
package wb_pkg;

    localparam int unsigned WB_DATA_WIDTH = 32;
    localparam int unsigned WB_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StErr  = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_watchdog.sv
// Saturating count of unacknowledged strobe cycles; flags the cycle whose count reaches TIMEOUT.
module wb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic i_CLK,
    input  logic i_RSTn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LP_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Expiry is flagged in the cycle whose increment reaches TIMEOUT, so ERR follows directly.
    assign o_expired = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter with per-CYC grant hold and a timeout watchdog.
module wb_rr_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic [ADDR_WIDTH-1:0] i_s_ADDR_0,
    input  logic [DATA_WIDTH-1:0] i_s_DATA_0,
    input  logic                  i_s_WE_0,
    input  logic [3:0]            i_s_SEL_0,
    input  logic                  i_s_STB_0,
    input  logic                  i_s_CYC_0,
    input  logic                  i_s_TAGN_0,
    output logic [DATA_WIDTH-1:0] o_s_DATA_0,
    output logic                  o_s_ACK_0,
    output logic                  o_s_ERR_0,
    output logic                  o_s_TAGN_0,
    input  logic [ADDR_WIDTH-1:0] i_s_ADDR_1,
    input  logic [DATA_WIDTH-1:0] i_s_DATA_1,
    input  logic                  i_s_WE_1,
    input  logic [3:0]            i_s_SEL_1,
    input  logic                  i_s_STB_1,
    input  logic                  i_s_CYC_1,
    input  logic                  i_s_TAGN_1,
    output logic [DATA_WIDTH-1:0] o_s_DATA_1,
    output logic                  o_s_ACK_1,
    output logic                  o_s_ERR_1,
    output logic                  o_s_TAGN_1,
    output logic [ADDR_WIDTH-1:0] o_m_ADDR,
    output logic [DATA_WIDTH-1:0] o_m_DATA,
    output logic                  o_m_WE,
    output logic [3:0]            o_m_SEL,
    output logic                  o_m_STB,
    output logic                  o_m_CYC,
    output logic                  o_m_TAGN,
    input  logic [DATA_WIDTH-1:0] i_m_DATA,
    input  logic                  i_m_ACK,
    input  logic                  i_m_TAGN,
    output logic [1:0]            o_GNT
);

    wb_state_e  r_state, w_state_d;
    logic [1:0] r_gnt, w_gnt_d;
    logic       r_ptr, w_ptr_d;

    logic w_sel;
    logic w_cyc_g;
    logic w_stb_g;
    logic w_busy;
    logic w_err;
    logic w_wd_en;
    logic w_wd_clr;
    logic w_expired;

    assign w_sel   = r_gnt[1];
    assign w_cyc_g = w_sel ? i_s_CYC_1 : i_s_CYC_0;
    assign w_stb_g = w_sel ? i_s_STB_1 : i_s_STB_0;
    assign w_busy  = (r_state == StBusy);
    assign w_err   = (r_state == StErr);

    assign w_wd_en  = w_busy && w_cyc_g && w_stb_g && !i_m_ACK;
    assign w_wd_clr = !w_wd_en;

    wb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .i_CLK    (i_CLK),
        .i_RSTn   (i_RSTn),
        .i_en     (w_wd_en),
        .i_clr    (w_wd_clr),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_state <= StIdle;
            r_gnt   <= 2'b00;
            r_ptr   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_gnt   <= w_gnt_d;
            r_ptr   <= w_ptr_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_gnt_d   = r_gnt;
        w_ptr_d   = r_ptr;
        case (r_state)
            StIdle: begin
                if (i_s_CYC_0 && (!i_s_CYC_1 || !r_ptr)) begin
                    w_gnt_d   = 2'b01;
                    w_state_d = StBusy;
                end else if (i_s_CYC_1) begin
                    w_gnt_d   = 2'b10;
                    w_state_d = StBusy;
                end
            end
            StBusy: begin
                // Releasing CYC takes precedence over a simultaneous expiry.
                if (!w_cyc_g) begin
                    w_gnt_d   = 2'b00;
                    w_ptr_d   = !w_sel;
                    w_state_d = StIdle;
                end else if (w_expired) begin
                    w_state_d = StErr;
                end
            end
            StErr: begin
                w_gnt_d   = 2'b00;
                w_ptr_d   = !w_sel;
                w_state_d = StIdle;
            end
            default: begin
                w_gnt_d   = 2'b00;
                w_state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        o_m_ADDR   = '0;
        o_m_DATA   = '0;
        o_m_WE     = 1'b0;
        o_m_SEL    = 4'h0;
        o_m_STB    = 1'b0;
        o_m_CYC    = 1'b0;
        o_m_TAGN   = 1'b0;
        o_s_DATA_0 = '0;
        o_s_ACK_0  = 1'b0;
        o_s_ERR_0  = 1'b0;
        o_s_TAGN_0 = 1'b0;
        o_s_DATA_1 = '0;
        o_s_ACK_1  = 1'b0;
        o_s_ERR_1  = 1'b0;
        o_s_TAGN_1 = 1'b0;
        if (w_busy) begin
            o_m_ADDR = w_sel ? i_s_ADDR_1 : i_s_ADDR_0;
            o_m_DATA = w_sel ? i_s_DATA_1 : i_s_DATA_0;
            o_m_WE   = w_sel ? i_s_WE_1   : i_s_WE_0;
            o_m_SEL  = w_sel ? i_s_SEL_1  : i_s_SEL_0;
            o_m_TAGN = w_sel ? i_s_TAGN_1 : i_s_TAGN_0;
            o_m_CYC  = w_cyc_g;
            o_m_STB  = w_stb_g && w_cyc_g;
            if (r_gnt[0]) begin
                o_s_DATA_0 = i_m_DATA;
                o_s_ACK_0  = i_m_ACK;
                o_s_TAGN_0 = i_m_TAGN;
            end
            if (r_gnt[1]) begin
                o_s_DATA_1 = i_m_DATA;
                o_s_ACK_1  = i_m_ACK;
                o_s_TAGN_1 = i_m_TAGN;
            end
        end
        if (w_err) begin
            o_s_ERR_0 = r_gnt[0];
            o_s_ERR_1 = r_gnt[1];
        end
    end

    assign o_GNT = r_gnt;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Randomized and directed checks of wb_rr_arbiter against a transaction-level ownership model.
module tb_wb_rr_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] s_addr  [2];
    logic [DW-1:0] s_wdata [2];
    logic          s_we    [2];
    logic [3:0]    s_sel   [2];
    logic          s_stb   [2];
    logic          s_cyc   [2];
    logic          s_tag   [2];
    logic [DW-1:0] s_rdata [2];
    logic          s_ack   [2];
    logic          s_err   [2];
    logic          s_tago  [2];
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_we;
    logic [3:0]    m_sel;
    logic          m_stb;
    logic          m_cyc;
    logic          m_tag;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          m_tagi;
    logic [1:0]    gnt;

    wb_rr_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO)
    ) dut (
        .i_CLK     (clk),
        .i_RSTn    (rst_n),
        .i_s_ADDR_0(s_addr[0]),
        .i_s_DATA_0(s_wdata[0]),
        .i_s_WE_0  (s_we[0]),
        .i_s_SEL_0 (s_sel[0]),
        .i_s_STB_0 (s_stb[0]),
        .i_s_CYC_0 (s_cyc[0]),
        .i_s_TAGN_0(s_tag[0]),
        .o_s_DATA_0(s_rdata[0]),
        .o_s_ACK_0 (s_ack[0]),
        .o_s_ERR_0 (s_err[0]),
        .o_s_TAGN_0(s_tago[0]),
        .i_s_ADDR_1(s_addr[1]),
        .i_s_DATA_1(s_wdata[1]),
        .i_s_WE_1  (s_we[1]),
        .i_s_SEL_1 (s_sel[1]),
        .i_s_STB_1 (s_stb[1]),
        .i_s_CYC_1 (s_cyc[1]),
        .i_s_TAGN_1(s_tag[1]),
        .o_s_DATA_1(s_rdata[1]),
        .o_s_ACK_1 (s_ack[1]),
        .o_s_ERR_1 (s_err[1]),
        .o_s_TAGN_1(s_tago[1]),
        .o_m_ADDR  (m_addr),
        .o_m_DATA  (m_wdata),
        .o_m_WE    (m_we),
        .o_m_SEL   (m_sel),
        .o_m_STB   (m_stb),
        .o_m_CYC   (m_cyc),
        .o_m_TAGN  (m_tag),
        .i_m_DATA  (m_rdata),
        .i_m_ACK   (m_ack),
        .i_m_TAGN  (m_tagi),
        .o_GNT     (gnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: who owns the bus, whether this is the error cycle, whose turn is next,
    // and how many consecutive strobe cycles have gone unanswered.
    int mdl_owner = -1;
    bit mdl_err   = 1'b0;
    int mdl_ptr   = 0;
    int mdl_wait  = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [127:0] e_req;
        logic [127:0] e_rsp;
        logic [127:0] e_gnt;
        int o;
        o = mdl_owner;
        e_req = '0;
        e_gnt = '0;
        if (o >= 0) begin
            e_gnt = 128'(1 << o);
            if (!mdl_err)
                e_req = 128'({s_addr[o], s_wdata[o], s_we[o], s_sel[o], s_stb[o] & s_cyc[o],
                              s_cyc[o], s_tag[o]});
        end
        check_eq({tag, "_gnt"}, 128'(gnt), e_gnt);
        check_eq({tag, "_req"}, 128'({m_addr, m_wdata, m_we, m_sel, m_stb, m_cyc, m_tag}), e_req);
        for (int n = 0; n < 2; n++) begin
            e_rsp = '0;
            if (o == n)
                e_rsp = mdl_err ? 128'({32'h0, 1'b0, 1'b1, 1'b0})
                                : 128'({m_rdata, m_ack, 1'b0, m_tagi});
            check_eq($sformatf("%s_rsp%0d", tag, n),
                     128'({s_rdata[n], s_ack[n], s_err[n], s_tago[n]}), e_rsp);
        end
    endtask

    task automatic model_edge();
        if (mdl_owner < 0) begin
            if (s_cyc[0] && s_cyc[1]) mdl_owner = mdl_ptr;
            else if (s_cyc[0])        mdl_owner = 0;
            else if (s_cyc[1])        mdl_owner = 1;
        end else if (mdl_err) begin
            mdl_ptr   = 1 - mdl_owner;
            mdl_owner = -1;
            mdl_err   = 1'b0;
            mdl_wait  = 0;
        end else if (!s_cyc[mdl_owner]) begin
            mdl_ptr   = 1 - mdl_owner;
            mdl_owner = -1;
            mdl_wait  = 0;
        end else if (s_stb[mdl_owner] && !m_ack) begin
            mdl_wait++;
            if (mdl_wait >= TO) mdl_err = 1'b1;
        end else begin
            mdl_wait = 0;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_outputs(tag);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic set_idle(input int n);
        s_cyc[n] = 1'b0;
        s_stb[n] = 1'b0;
    endtask

    task automatic set_req(input int n, input logic [AW-1:0] addr);
        s_addr[n]  = addr;
        s_wdata[n] = $urandom;
        s_we[n]    = 1'b0;
        s_sel[n]   = 4'hF;
        s_tag[n]   = 1'($urandom);
        s_cyc[n]   = 1'b1;
        s_stb[n]   = 1'b1;
    endtask

    task automatic model_reset();
        mdl_owner = -1;
        mdl_err   = 1'b0;
        mdl_ptr   = 0;
        mdl_wait  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int n = 0; n < 2; n++) begin
            set_idle(n);
            s_addr[n]  = '0;
            s_wdata[n] = '0;
            s_we[n]    = 1'b0;
            s_sel[n]   = 4'h0;
            s_tag[n]   = 1'b0;
        end
        m_rdata = 32'h1234_5678;
        m_ack   = 1'b1;
        m_tagi  = 1'b1;
        #2;
        check_outputs("reset");
        @(posedge clk);
        #1;
        m_ack = 1'b0;
        rst_n = 1'b1;

        // Contention after reset: M0 first, then M1 on the next round.
        set_req(0, 32'h2000_0000);
        set_req(1, 32'h3000_0000);
        step("cont_req");
        check_eq("cont_first", 128'(gnt), 128'(2'b01));
        m_ack = 1'b1;
        step("cont_ack");
        m_ack = 1'b0;
        set_idle(0);
        step("cont_drop");
        check_eq("cont_gap", 128'(gnt), 128'(2'b00));
        set_req(0, 32'h2000_0010);
        step("cont_again");
        check_eq("cont_second", 128'(gnt), 128'(2'b10));

        // Burst hold: four beats from M1 while M0 keeps requesting.
        for (int b = 0; b < 4; b++) begin
            step("burst_wait");
            m_ack   = 1'b1;
            m_rdata = 32'hB000_0000 + 32'(b);
            #1;
            check_eq("burst_ack", 128'({gnt, s_ack[1], s_ack[0]}), 128'({2'b10, 1'b1, 1'b0}));
            step("burst_beat");
            m_ack = 1'b0;
        end
        set_idle(1);
        step("burst_end");
        step("burst_m0");
        check_eq("burst_next", 128'(gnt), 128'(2'b01));
        m_ack = 1'b1;
        step("m0_ack");
        m_ack = 1'b0;
        set_idle(0);
        step("m0_drop");

        // Single master read acknowledged two cycles after the grant.
        set_req(0, 32'h1000_0004);
        step("single_req");
        check_eq("single_gnt", 128'(gnt), 128'(2'b01));
        step("single_wait");
        m_ack   = 1'b1;
        m_rdata = 32'hDEAD_BEEF;
        #1;
        check_eq("single_data", 128'({s_ack[0], s_rdata[0], s_ack[1]}),
                 128'({1'b1, 32'hDEAD_BEEF, 1'b0}));
        step("single_ack");
        m_ack = 1'b0;
        set_idle(0);
        step("single_drop");

        // Timeout with no slave response, then a late ACK.
        set_req(0, 32'h4000_0000);
        step("to_req");
        for (int k = 1; k <= TO; k++) step("to_wait");
        check_eq("to_err", 128'({s_err[0], s_err[1]}), 128'(2'b10));
        set_idle(0);
        m_ack = 1'b1;
        #1;
        check_eq("to_late_in_err", 128'(s_ack[0]), 128'(0));
        step("to_errcyc");
        check_eq("to_release", 128'({gnt, s_ack[0], s_err[0]}), 128'(0));
        step("to_late");
        m_ack = 1'b0;

        // ACK on the expiry cycle wins.
        set_req(0, 32'h4000_0004);
        step("exp_req");
        for (int k = 1; k < TO; k++) step("exp_wait");
        m_ack = 1'b1;
        #1;
        check_eq("exp_ack", 128'({s_ack[0], s_err[0]}), 128'(2'b10));
        step("exp_ackcyc");
        m_ack = 1'b0;
        check_eq("exp_no_err", 128'({gnt, s_err[0]}), 128'({2'b01, 1'b0}));
        set_idle(0);
        step("exp_drop");

        // Asynchronous reset while busy.
        set_req(0, 32'h5000_0000);
        step("ar_req");
        step("ar_busy");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("ar_inreset");
        set_idle(0);
        set_req(1, 32'h5000_0100);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("ar_m1");
        check_eq("ar_grant", 128'(gnt), 128'(2'b10));
        set_idle(1);
        step("ar_drop");

        // Randomized traffic with periods of a silent slave.
        for (int i = 0; i < 1500; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (s_cyc[n]) begin
                    if ($urandom_range(0, 7) == 0) s_cyc[n] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    s_cyc[n] = 1'b1;
                end
                s_stb[n]   = s_cyc[n] && ($urandom_range(0, 3) != 0);
                s_addr[n]  = $urandom;
                s_wdata[n] = $urandom;
                s_we[n]    = 1'($urandom);
                s_sel[n]   = 4'($urandom);
                s_tag[n]   = 1'($urandom);
            end
            m_ack   = ((i / 60) % 3 == 2) ? 1'b0 : ($urandom_range(0, 3) == 0);
            m_rdata = $urandom;
            m_tagi  = 1'($urandom);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
